// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter (start, data LSB-first, optional parity, 1/2 stop)
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  input  logic [1:0]            i_parity_mode,
  input  logic                  i_stop2,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  timer;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  par_en;
  logic                  par_bit;
  logic                  stop2_q;
  logic                  stop_cnt;
  logic                  bit_end;

  // The word is kept in a shift register so the next data bit is always bit 0.
  assign shift_next = shift >> 1;
  assign bit_end    = (timer == div_q);

  // Handshake status follows the state register directly.
  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);

  // Frame sequencer: bit timer, bit/stop counters and the registered line level.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      timer    <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2_q  <= 1'b0;
      stop_cnt <= 1'b0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx     <= 1'b1;
          timer    <= '0;
          bit_idx  <= '0;
          stop_cnt <= 1'b0;
          if (i_valid) begin
            // Capture the whole frame format so later input changes cannot disturb it.
            shift   <= i_data;
            div_q   <= i_baud_div;
            stop2_q <= i_stop2;
            par_en  <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
            par_bit <= (i_parity_mode == 2'b10) ? ~^i_data : ^i_data;
            o_tx    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            o_tx    <= shift[0];
            state   <= DATA;
          end else begin
            timer <= timer + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == LAST_IDX) begin
              stop_cnt <= 1'b0;
              if (par_en) begin
                o_tx  <= par_bit;
                state <= PARITY;
              end else begin
                o_tx  <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shift   <= shift_next;
              o_tx    <= shift_next[0];
            end
          end else begin
            timer <= timer + DIV_WIDTH'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            timer    <= '0;
            stop_cnt <= 1'b0;
            o_tx     <= 1'b1;
            state    <= STOP;
          end else begin
            timer <= timer + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          o_tx <= 1'b1;
          if (bit_end) begin
            timer <= '0;
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              stop_cnt <= 1'b0;
              o_done   <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            timer <= timer + DIV_WIDTH'(1);
          end
        end
        default: begin
          o_tx  <= 1'b1;
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg with a bit-list reference model
module tb_uart_tx_cfg;

  localparam int DW = 8;
  localparam int VW = 16;

  logic          clk;
  logic          rstn;
  logic [VW-1:0] baud_div;
  logic [1:0]    parity_mode;
  logic          stop2;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          tx;
  logic          busy;
  logic          done;

  int checks = 0;
  int passed = 0;

  uart_tx_cfg #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_baud_div    (baud_div),
    .i_parity_mode (parity_mode),
    .i_stop2       (stop2),
    .i_valid       (valid),
    .i_data        (data),
    .o_ready       (ready),
    .o_tx          (tx),
    .o_busy        (busy),
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
    $fatal(1);
  end

  // Reference model: list of line levels for one frame, one entry per bit period.
  logic exp_bits [0:15];
  int   exp_nbits;

  task automatic build_frame(input logic [DW-1:0] d, input logic [1:0] pm, input logic s2);
    int ones;
    ones = 0;
    exp_nbits = 0;
    exp_bits[exp_nbits] = 1'b0; exp_nbits++;
    for (int i = 0; i < DW; i++) begin
      exp_bits[exp_nbits] = d[i]; exp_nbits++;
      ones += int'(d[i]);
    end
    if (pm == 2'b01) begin
      exp_bits[exp_nbits] = ((ones % 2) == 1); exp_nbits++;
    end else if (pm == 2'b10) begin
      exp_bits[exp_nbits] = ((ones % 2) == 0); exp_nbits++;
    end
    exp_bits[exp_nbits] = 1'b1; exp_nbits++;
    if (s2) begin
      exp_bits[exp_nbits] = 1'b1; exp_nbits++;
    end
  endtask

  // Called at a negedge. Accepts one frame and checks every cycle of it plus the done cycle.
  // hold=1 keeps valid/data/config unchanged during the frame; otherwise they are scrambled.
  task automatic run_frame(input string name, input logic [DW-1:0] d, input logic [VW-1:0] div,
                           input logic [1:0] pm, input logic s2, input bit hold);
    int n;
    int nper;
    int flen;
    n = 0;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) $display("FAIL %s ready_wait: got ready=%b expected 1", name, ready);
    else passed++;
    build_frame(d, pm, s2);
    nper = int'(div) + 1;
    flen = exp_nbits * nper;
    valid = 1'b1; data = d; baud_div = div; parity_mode = pm; stop2 = s2;
    @(posedge clk);
    for (int c = 0; c < flen; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) begin
        valid       = 1'b0;
        data        = DW'($urandom);
        baud_div    = VW'($urandom_range(0, 9));
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
      end
      checks++;
      if (tx !== exp_bits[c / nper] || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0)
        $display("FAIL %s cycle %0d: got tx=%b busy=%b ready=%b done=%b expected tx=%b busy=1 ready=0 done=0",
                 name, c, tx, busy, ready, done, exp_bits[c / nper]);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL %s end_of_frame: got done=%b ready=%b busy=%b tx=%b expected done=1 ready=1 busy=0 tx=1",
               name, done, ready, busy, tx);
    else passed++;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || tx !== 1'b1 || ready !== 1'b1)
      $display("FAIL %s idle: got done=%b tx=%b ready=%b expected done=0 tx=1 ready=1", name, done, tx, ready);
    else passed++;
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid = 1'b0; data = '0; baud_div = '0; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_values: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0", tx, ready, busy, done);
    else passed++;
    rstn = 1'b1;
    idle_check("after_reset");
  endtask

  task automatic test_basic();
    run_frame("a5_div3", 8'hA5, 16'd3, 2'b00, 1'b0, 1'b0);
    idle_check("a5_div3");
  endtask

  task automatic test_parity();
    run_frame("07_even", 8'h07, 16'd0, 2'b01, 1'b0, 1'b0);
    idle_check("07_even");
    run_frame("07_odd", 8'h07, 16'd0, 2'b10, 1'b0, 1'b0);
    idle_check("07_odd");
    run_frame("81_mode3", 8'h81, 16'd2, 2'b11, 1'b0, 1'b0);
    idle_check("81_mode3");
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_00", 8'h00, 16'd2, 2'b00, 1'b1, 1'b1);
    run_frame("b2b_ff", 8'hFF, 16'd2, 2'b00, 1'b1, 1'b1);
    valid = 1'b0;
    idle_check("b2b_ff");
  endtask

  task automatic test_cfg_change();
    run_frame("cfg_old", 8'h5A, 16'd3, 2'b00, 1'b0, 1'b0);
    run_frame("cfg_new", 8'h5B, 16'd7, 2'b01, 1'b0, 1'b0);
    idle_check("cfg_new");
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d;
    d = DW'($urandom);
    valid = 1'b1; data = d; baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    @(posedge clk);
    repeat (4 * 4 + 2) @(negedge clk);
    valid = 1'b0;
    checks++;
    if (tx !== d[3]) $display("FAIL mid_reset_bit3: got tx=%b expected %b", tx, d[3]);
    else passed++;
    rstn = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset_async: got tx=%b ready=%b done=%b busy=%b expected 1 1 0 0", tx, ready, done, busy);
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    idle_check("mid_reset_release");
    run_frame("after_reset_3c", 8'h3C, 16'd3, 2'b00, 1'b0, 1'b0);
    idle_check("after_reset_3c");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_frame("random", DW'($urandom), VW'($urandom_range(0, 5)), 2'($urandom), 1'($urandom), 1'($urandom));
      valid = 1'b0;
      if ($urandom_range(0, 1) == 1) idle_check("random");
    end
    idle_check("random_end");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter. It accepts one word per valid/ready handshake and serialises it LSB-first as start bit, DATA_WIDTH data bits, an optional parity bit and one or two stop bits. An internal baud divider sets the bit period. It sits between a byte source (FIFO or register interface) and the chip TX pad and replaces the fixed-format transmitter.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame; legal range 1..16.
- DIV_WIDTH, 16: width of the baud divider input.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_baud_div  in  DIV_WIDTH  bit period minus one: each bit lasts i_baud_div+1 clocks; 0 is legal (1 clock per bit).
- i_parity_mode  in  2  00 = none, 01 = even, 10 = odd, 11 = none.
- i_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- i_valid  in  1  source has a word on i_data.
- i_data  in  DATA_WIDTH  word to send.
- o_ready  out  1  block can accept a word; high only in IDLE.
- o_tx  out  1  serial line, registered, idles high.
- o_busy  out  1  frame in progress; always the inverse of o_ready.
- o_done  out  1  one-clock pulse when a frame's last stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when i_valid && o_ready at a clock edge (accept).
- On accept, the block latches i_data, i_baud_div, i_parity_mode and i_stop2. Input changes during a frame have no effect on that frame.
- Bit timer counts 0..div_latched. A bit ends on the clock where the timer equals div_latched; the timer then returns to 0.
- START (o_tx = 0): one bit period, then -> DATA.
- DATA (o_tx = data_latched[bit_idx]): bit_idx runs 0..DATA_WIDTH-1, one bit period each.
  - After bit DATA_WIDTH-1 -> PARITY if parity is enabled, else -> STOP.
- PARITY: o_tx = ^data_latched for even, ~^data_latched for odd; one bit period, then -> STOP.
- STOP (o_tx = 1): one bit period, or two if i_stop2 was latched as 1 (stop counter); then -> IDLE.
  - On that transition o_done pulses and o_ready rises.
- IDLE: o_tx = 1, o_ready = 1.
- i_parity_mode = 11 behaves exactly as 00.
- Reset values: o_tx = 1, o_ready = 1, o_busy = 0, o_done = 0. FSM = IDLE, all counters = 0.
- Reset asserted mid-frame: the frame is abandoned and o_tx returns to 1 asynchronously. No o_done pulse is produced. The next accepted frame is complete and correct.
- i_valid while o_ready = 0 is ignored; the source must hold i_valid and i_data until accepted.

## Timing
- Let N = i_baud_div+1, P = 1 if parity is enabled else 0, S = stop bits, F = (1 + DATA_WIDTH + P + S) * N.
- Accept at edge k: o_tx = 0 is visible after edge k (registered; no extra latency).
- Data bit i is driven during edges k+(1+i)*N through k+(2+i)*N-1.
- FSM returns to IDLE at edge k+F. o_done = 1 and o_ready = 1 for the cycle following edge k+F.
- Earliest next accept is edge k+F+1, so back-to-back frames carry one extra idle-high clock after the stop bit(s).
- o_done is never high in two consecutive cycles.

## Test plan
- DATA_WIDTH=8, div=3, parity none, 1 stop, data 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks; o_done pulses 40 clocks after accept.
- div=0, data 0x07, even parity -> parity bit 1; repeat with odd parity -> parity bit 0. Frame length is 11 clocks in both runs.
- i_stop2=1, i_valid held high with 0x00 then 0xFF -> stop high for 2N, one idle clock, then the second start bit. o_ready is high exactly one cycle between frames.
- Change i_baud_div from 3 to 7 and i_parity_mode from 00 to 01 mid-frame -> the current frame keeps N=4 and no parity; the next frame uses N=8 with even parity.
- Pull i_rstn low during data bit 3 -> o_tx = 1, o_ready = 1, o_done = 0 immediately; after release, frame 0x3C is transmitted correctly.
- i_parity_mode=11, data 0x81 -> waveform is identical to parity none.
